// File: rtl/irq_sched.sv
// Interrupt scheduler: latches and masks 32 sources, offers the lowest pending one to the core
// with a req/ack/EOI handshake. The optional countdown timer on IRQ 0 is enabled by IRQ_SCHED_TIMER_EN.
module irq_sched #(
  parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
  parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
  parameter int          EOI_DELAY   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] irq_i,
  input  logic        mask_wr_i,
  input  logic [31:0] mask_wdata_i,
  output logic [31:0] irq_mask_o,
  output logic [31:0] irq_pending_o,
  output logic        irq_req_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  output logic        irq_active_o,
  input  logic        eoi_valid_i,
  output logic [31:0] eoi_o,
  input  logic        timer_wr_i,
  input  logic [31:0] timer_wdata_i,
  output logic [31:0] timer_q_o
);

  // state    | meaning
  // S_IDLE   | waiting for an unmasked pending source
  // S_REQ    | irq_req high, irq_id frozen until ack
  // S_ACTIVE | handler running, waiting for EOI
  // S_DELAY  | EOI_DELAY idle cycles before the next request
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE, S_DELAY} state_t;

  localparam logic [1:0] DLY_LOAD = 2'((EOI_DELAY > 0) ? (EOI_DELAY - 1) : 0);

  state_t      state_q;
  logic [31:0] mask_q, mask_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  id_q;
  logic        req_q, active_q;
  logic [31:0] eoi_q;
  logic [1:0]  dly_q;
  logic [31:0] tmr_q;
  logic        tmr_fire;
  logic [31:0] irq_src, pend_next, ack_clr, cand;
  logic [4:0]  sel_id;
  logic        sel_vld;

`ifdef IRQ_SCHED_TIMER_EN
  // A load in the same cycle as the 1->0 step cancels the interrupt.
  always_ff @(posedge clk) begin
    if (!resetn)              tmr_q <= 32'd0;
    else if (timer_wr_i)      tmr_q <= timer_wdata_i;
    else if (tmr_q != 32'd0)  tmr_q <= tmr_q - 32'd1;
  end
  assign tmr_fire = !timer_wr_i && (tmr_q == 32'd1);
`else
  logic unused_tmr;
  assign unused_tmr = ^{timer_wr_i, timer_wdata_i};
  assign tmr_q      = 32'd0;
  assign tmr_fire   = 1'b0;
`endif

  always_comb begin
    irq_src   = irq_i | {31'd0, tmr_fire};
    pend_next = (((pending_q | irq_src) & LATCHED_IRQ) | (irq_src & ~LATCHED_IRQ)) & ~MASKED_IRQ;
    ack_clr   = 32'd0;
    if (state_q == S_REQ && irq_ack_i) ack_clr = 32'd1 << id_q;
    // A fresh assertion on the ack edge keeps the source pending.
    pending_d = pend_next & ~(ack_clr & ~irq_src);
    mask_d    = mask_wr_i ? mask_wdata_i : mask_q;
  end

  always_comb begin
    cand    = pending_q & ~mask_q;
    sel_vld = 1'b0;
    sel_id  = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (cand[i]) begin
        sel_vld = 1'b1;
        sel_id  = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mask_q    <= 32'hffff_ffff;
      pending_q <= 32'd0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      id_q     <= 5'd0;
      req_q    <= 1'b0;
      active_q <= 1'b0;
      eoi_q    <= 32'd0;
      dly_q    <= 2'd0;
    end else begin
      eoi_q <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            state_q <= S_REQ;
            id_q    <= sel_id;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (irq_ack_i) begin
            state_q  <= S_ACTIVE;
            req_q    <= 1'b0;
            active_q <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (eoi_valid_i) begin
            eoi_q    <= 32'd1 << id_q;
            active_q <= 1'b0;
            dly_q    <= DLY_LOAD;
            state_q  <= (EOI_DELAY == 0) ? S_IDLE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_q == 2'd0) state_q <= S_IDLE;
          else               dly_q   <= dly_q - 2'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_mask_o    = mask_q;
  assign irq_pending_o = pending_q;
  assign irq_req_o     = req_q;
  assign irq_id_o      = id_q;
  assign irq_active_o  = active_q;
  assign eoi_o         = eoi_q;
  assign timer_q_o     = tmr_q;

endmodule
